fp_fma_arbiter: RTL
===================

Name: fp_fma_arbiter

Overview:
- Sequences and shares one multi-cycle fused multiply-add unit between two requesters.
  - Requester 0: integer/FP issue pipeline.
  - Requester 1: auxiliary FP issue port.
- Round-robin grant; exactly one operation in flight.
- Resolves the dynamic rounding mode, drives the unit's start/done handshake and returns tagged results with fflags.
- Provides flush, watchdog timeout and accrued-flag tracking.

Parameters:
- FLEN, 32, operand width (32 or 64).
- TAG_W, 5, requester tag width (destination register id).
- TIMEOUT, 32, maximum cycles waited for unit done; minimum 8.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept.
- req_op  in  4  {op1,op0}, 2b FMA op each (00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD).
- req_rm  in  6  {rm1,rm0}, 3b rounding mode each.
- req_a, req_b, req_c  in  2*FLEN each  {op1,op0} operands.
- req_tag  in  2*TAG_W  {tag1,tag0}.
- flush  in  2  per-requester cancel.
- frm  in  3  fcsr dynamic rounding mode.
- fu_start  out  1  start pulse to FMA unit.
- fu_fma_op  out  2  registered op.
- fu_rm  out  3  resolved rounding mode.
- fu_a, fu_b, fu_c  out  FLEN each  registered operands.
- fu_busy  in  1  unit busy.
- fu_done  in  1  unit done pulse.
- fu_result  in  FLEN  unit result.
- fu_nv, fu_of, fu_uf, fu_nx  in  1 each  unit flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester index.
- rsp_tag  out  TAG_W  captured tag.
- rsp_result  out  FLEN  result.
- rsp_fflags  out  5  {NV,DZ,OF,UF,NX}.
- rsp_err  out  1  1 = illegal rm or timeout.
- fflags_accrued  out  5  sticky OR of delivered rsp_fflags.
- fflags_clr  in  1  clear accrued flags.

Behaviour:
- Reset (async): state IDLE, rr pointer = 0 (requester 0 preferred). All outputs 0: fu_start, rsp_valid, rsp_err, rsp_id, rsp_tag, rsp_result, rsp_fflags, fflags_accrued, fu_* data.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = requester i with req_valid[i] && !flush[i]; if both qualify, pick pointer side.
  - req_ready[i] = (state==IDLE) && grant==i (combinational). req_ready is 0 in all other states.
  - On accept: register op, operands, tag and owner id.
  - Resolve rm: 111 -> frm. If the resolved value is 101, 110 or 111, the request is illegal: go to RESP with rsp_err=1, rsp_result = canonical NaN (32'h7FC00000 / 64'h7FF8000000000000), fflags=0, and the unit is never started.
  - Otherwise -> ISSUE.
- ISSUE: fu_start=1 for exactly one cycle, in the first cycle fu_busy=0; stay in ISSUE while fu_busy=1. Timer cleared on start -> WAIT.
- WAIT:
  - Timer increments each cycle.
  - fu_done: capture fu_result and fflags = {fu_nv,0,fu_of,fu_uf,fu_nx} -> RESP.
  - Timer == TIMEOUT-1 without done: -> RESP with rsp_err=1, canonical NaN, fflags=0.
  - fu_done on the same cycle as timeout: done wins.
  - fu_done outside WAIT is ignored.
- RESP:
  - rsp_valid=1 and payload stable until rsp_ready.
  - On handshake: fflags_accrued |= rsp_fflags (rsp_err responses contribute 0); pointer = ~owner; -> IDLE.
  - Next accept is possible the cycle after the handshake (one-cycle bubble).
- Flush:
  - flush[owner] in ISSUE (before start) -> IDLE immediately, no start.
  - flush[owner] in WAIT -> set kill; on done/timeout go to IDLE with no response; pointer still toggles.
  - flush[owner] in RESP -> rsp_valid drops next cycle, no accrual, -> IDLE. A simultaneous rsp_ready counts as delivered (handshake wins).
  - flush of the non-owner has no effect.
- fflags_clr has priority over a same-cycle accrual (result 0).
- Latency: accept cycle t, fu_start at t+1 (fu_busy=0), rsp_valid the cycle after fu_done.
- Reset mid-operation aborts everything; the pending response is lost.

Test Plan:
1. Single op: req0 FMADD, a=0x3F800000, b=0x40000000, c=0x3F800000, rm=000, tag=3; unit model returns 0x40400000 6 cycles after start -> one fu_start at t+1; rsp_valid with id=0, tag=3, result=0x40400000, fflags=0, err=0.
2. Contention: both valid continuously after reset -> grants 0,1,0,1; the other requester's req_ready stays 0 while busy; exactly one fu_start per grant.
3. Dynamic rm: req_rm=111, frm=011 -> fu_rm=011. frm=101 -> no fu_start, rsp_err=1, result 0x7FC00000.
4. Flush during WAIT on req1 -> no response for that op; next req0 granted after done.
5. Timeout: model never asserts done, TIMEOUT=32 -> rsp_err=1 exactly 32 cycles after fu_start, result 0x7FC00000.
6. Flags/backpressure: model returns nv=1, nx=1; rsp_ready held low 5 cycles -> payload stable; fflags_accrued=5'b10001 after handshake; fflags_clr -> 0.

Source files
------------

// File: rtl/fp_fma_arbiter.sv
// fp_fma_arbiter
//   Shares one multi-cycle fused multiply-add unit between two requesters
//   (0: integer/FP issue pipeline, 1: auxiliary FP issue port). Round-robin
//   grant with exactly one operation in flight. Resolves the dynamic rounding
//   mode, drives the unit start/done handshake, returns tagged results with
//   fflags, and handles flush, a done watchdog and sticky accrued flags.
//
// Ports
//   clk, reset_n           clock, async active-low reset
//   req_valid/req_ready    per-requester handshake (index 1 = upper slice)
//   req_op/rm/a/b/c/tag    packed {req1,req0} request payload
//   flush                  per-requester cancel of its in-flight operation
//   frm                    dynamic rounding mode used when rm = 3'b111
//   fu_*                   FMA unit command, status and result
//   rsp_*                  tagged response, held until rsp_ready
//   fflags_accrued/_clr    sticky OR of delivered fflags, and its clear
//
// State table
//   IDLE  | waiting for a qualified request; req_ready asserted for the grant
//   ISSUE | operation latched; pulse fu_start once the unit is not busy
//   WAIT  | unit running; watchdog counting down towards timeout
//   RESP  | response presented until rsp_ready (or dropped on owner flush)

module fp_fma_arbiter #(
  parameter int FLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req_op,
  input  logic [5:0]           req_rm,
  input  logic [2*FLEN-1:0]    req_a,
  input  logic [2*FLEN-1:0]    req_b,
  input  logic [2*FLEN-1:0]    req_c,
  input  logic [2*TAG_W-1:0]   req_tag,
  input  logic [1:0]           flush,
  input  logic [2:0]           frm,
  output logic                 fu_start,
  output logic [1:0]           fu_fma_op,
  output logic [2:0]           fu_rm,
  output logic [FLEN-1:0]      fu_a,
  output logic [FLEN-1:0]      fu_b,
  output logic [FLEN-1:0]      fu_c,
  input  logic                 fu_busy,
  input  logic                 fu_done,
  input  logic [FLEN-1:0]      fu_result,
  input  logic                 fu_nv,
  input  logic                 fu_of,
  input  logic                 fu_uf,
  input  logic                 fu_nx,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic [FLEN-1:0]      rsp_result,
  output logic [4:0]           rsp_fflags,
  output logic                 rsp_err,
  output logic [4:0]           fflags_accrued,
  input  logic                 fflags_clr
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [FLEN-1:0] CANON_NAN = (FLEN == 64) ? FLEN'(64'h7FF8000000000000)
                                                       : FLEN'(32'h7FC00000);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic              kill_q, kill_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        rm_q, rm_d;
  logic [FLEN-1:0]   a_q, a_d;
  logic [FLEN-1:0]   b_q, b_d;
  logic [FLEN-1:0]   c_q, c_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [FLEN-1:0]   res_q, res_d;
  logic [4:0]        flags_q, flags_d;
  logic              err_q, err_d;
  logic [4:0]        accr_q, accr_d;

  logic [1:0]        qual;
  logic              gnt_vld;
  logic              gnt_id;
  logic [2:0]        rm_sel;
  logic [2:0]        rm_res;
  logic              rm_illegal;
  logic              owner_flush;
  logic              kill_nxt;

  // A flushing requester never competes; on a tie the pointer side wins.
  assign qual    = req_valid & ~flush;
  assign gnt_vld = |qual;
  assign gnt_id  = (&qual) ? ptr_q : qual[1];

  assign rm_sel     = gnt_id ? req_rm[5:3] : req_rm[2:0];
  assign rm_res     = (rm_sel == 3'b111) ? frm : rm_sel;
  assign rm_illegal = rm_res[2] && (rm_res[1:0] != 2'b00);

  assign owner_flush = flush[owner_q];
  // A flush arriving on the same cycle as done/timeout still kills the op.
  assign kill_nxt    = kill_q | owner_flush;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    kill_d    = kill_q;
    tmr_d     = tmr_q;
    op_d      = op_q;
    rm_d      = rm_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    tag_d     = tag_q;
    res_d     = res_q;
    flags_d   = flags_q;
    err_d     = err_q;
    accr_d    = accr_q;
    req_ready = 2'b00;
    fu_start  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          req_ready = gnt_id ? 2'b10 : 2'b01;
          owner_d   = gnt_id;
          op_d      = gnt_id ? req_op[3:2] : req_op[1:0];
          rm_d      = rm_res;
          a_d       = gnt_id ? req_a[2*FLEN-1:FLEN] : req_a[FLEN-1:0];
          b_d       = gnt_id ? req_b[2*FLEN-1:FLEN] : req_b[FLEN-1:0];
          c_d       = gnt_id ? req_c[2*FLEN-1:FLEN] : req_c[FLEN-1:0];
          tag_d     = gnt_id ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
          kill_d    = 1'b0;
          if (rm_illegal) begin
            // Reserved rounding mode: answer directly, unit untouched.
            res_d   = CANON_NAN;
            flags_d = 5'b00000;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (owner_flush) begin
          ptr_d   = ~owner_q;
          state_d = S_IDLE;
        end else if (!fu_busy) begin
          fu_start = 1'b1;
          // Down-counter reaches zero in the cycle TIMEOUT-1 after start,
          // so a missing done yields a response TIMEOUT cycles after start.
          tmr_d    = TMR_W'(TIMEOUT - 2);
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        kill_d = kill_nxt;
        if (fu_done) begin
          if (kill_nxt) begin
            ptr_d   = ~owner_q;
            state_d = S_IDLE;
          end else begin
            res_d   = fu_result;
            flags_d = {fu_nv, 1'b0, fu_of, fu_uf, fu_nx};
            err_d   = 1'b0;
            state_d = S_RESP;
          end
        end else if (tmr_q == '0) begin
          if (kill_nxt) begin
            ptr_d   = ~owner_q;
            state_d = S_IDLE;
          end else begin
            res_d   = CANON_NAN;
            flags_d = 5'b00000;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_RESP: begin
        // Handshake takes precedence over a same-cycle owner flush.
        if (rsp_ready) begin
          accr_d  = accr_q | (err_q ? 5'b00000 : flags_q);
          ptr_d   = ~owner_q;
          state_d = S_IDLE;
        end else if (owner_flush) begin
          ptr_d   = ~owner_q;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (fflags_clr) begin
      accr_d = 5'b00000;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      kill_q  <= 1'b0;
      tmr_q   <= '0;
      op_q    <= 2'b00;
      rm_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      flags_q <= 5'b00000;
      err_q   <= 1'b0;
      accr_q  <= 5'b00000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      kill_q  <= kill_d;
      tmr_q   <= tmr_d;
      op_q    <= op_d;
      rm_q    <= rm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      accr_q  <= accr_d;
    end
  end

  assign fu_fma_op      = op_q;
  assign fu_rm          = rm_q;
  assign fu_a           = a_q;
  assign fu_b           = b_q;
  assign fu_c           = c_q;
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_id         = owner_q;
  assign rsp_tag        = tag_q;
  assign rsp_result     = res_q;
  assign rsp_fflags     = flags_q;
  assign rsp_err        = err_q;
  assign fflags_accrued = accr_q;

endmodule
